ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage that consumes the ID/EX pipeline register outputs and produces the EX/MEM register contents.
- Per-operand forwarding muxes.
- Single-cycle 64-bit ALU.
- Branch compare and target generation.
- Iterative multiply/divide unit that stalls the upstream pipeline while busy.
- All results leave through an internal EX/MEM register with 1-cycle latency.

Parameters:
XLEN, 64, datapath width
MD_CYCLES, 64, iterations of the multiply/divide engine (must equal XLEN)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
pc_in  input  XLEN  PC of the instruction in EX
funct_in  input  4  {funct7[5], funct3}
fun3_in  input  3  funct3
md_in  input  1  funct7[0] of an R-type instruction (M-extension op)
aluop_in  input  2  00 add, 01 branch, 10 R/I-type
memtoreg_in, regwrite_in, branch_in, memwrite_in, memread_in, alusrc_in  input  1 each  control bits
rs1_data_in, rs2_data_in, imm_in  input  XLEN  operands and immediate
rd_in  input  5  destination register
fwd_a, fwd_b  input  2  operand source: 00 register file, 01 memwb_data, 10 exmem_data, 11 reserved (register file)
exmem_data, memwb_data  input  XLEN  forwarded values
stall_out  output  1  hold PC, IF/ID and ID/EX
result_out  output  XLEN  registered ALU or mul/div result
store_data_out  output  XLEN  registered forwarded rs2 value
rd_out  output  5  registered destination register
memtoreg_out, regwrite_out, memwrite_out, memread_out  output  1 each  registered control bits
fun3_out  output  3  registered funct3 (load/store size)
branch_taken_out  output  1  registered taken-branch flag
branch_target_out  output  XLEN  registered pc_in + imm_in

Behaviour:
- Reset: all outputs 0; FSM to IDLE; multiply/divide accumulators cleared. Reset asserted mid-operation aborts the operation with no result written.
- Operand A = fwd_a mux. Operand B = imm_in if alusrc_in=1, else the fwd_b mux.
- store_data = the fwd_b mux, independent of alusrc_in.
- ALU by aluop_in:
  - 00: A+B.
  - 01: A-B. Branch condition from fun3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 10, by funct_in: 0000 add, 1000 sub, 0111 and, 0110 or, 0100 xor, 0001 sll, 0101 srl, 1101 sra, 0010 slt, 0011 sltu.
  - Shift amounts use B[5:0]. Add/sub wrap modulo 2^XLEN.
- Unknown funct_in or aluop_in=11: result 0; control bits still propagate.
- branch_taken = branch_in & condition. Target = pc_in+imm_in; imm_in is already a byte offset.
- Mul/div op = aluop_in=10 & md_in=1 & alusrc_in=0. Supported fun3: 000 MUL (low XLEN bits), 101 DIVU, 111 REMU. Other fun3 with md_in=1 yield result 0 with no stall.
- FSM IDLE -> BUSY -> DONE -> IDLE:
  - IDLE with a mul/div op: latch operands, stall_out=1 combinationally in that same cycle, EX/MEM receives a bubble (all control outputs 0), go to BUSY.
  - BUSY: one shift-add or restoring-division step per cycle for MD_CYCLES cycles. stall_out=1, bubbles keep being inserted.
  - DONE: stall_out=0; the result plus the latched rd/control are written to EX/MEM at the next edge; go to IDLE.
  - Total: an op first seen at edge N is registered at edge N+MD_CYCLES+2.
- DIVU/REMU by zero: quotient all ones, remainder = dividend. No trap.
- Non-mul/div instructions in IDLE pass through with 1-cycle latency and stall_out=0.
- Inputs are ignored in BUSY/DONE; upstream holds ID/EX stable because of stall_out.

Optional Feature:
MULDIV_EN defined:
- Multiply/divide engine and FSM are compiled in as above.

MULDIV_EN undefined:
- No FSM; stall_out tied 0.
- Mul/div ops produce result 0 with regwrite passed through, in a single cycle.

Test Plan:
- Reset asserted during BUSY of a DIVU -> all outputs 0 and stall_out=0 next cycle; a following add executes normally.
- aluop=10, funct=1000, A=5, B=7 -> result_out=0xFFFF_FFFF_FFFF_FFFE one cycle later; stall_out never asserted.
- fwd_a=10, exmem_data=0x10, rs1=0x99, alusrc=1, imm=8, aluop=00 -> result_out=0x18.
- branch_in=1, fun3=100, A=-1, B=1, pc=0x100, imm=0x20 -> branch_taken_out=1, branch_target_out=0x120.
- MUL 0x1_0000_0000 * 0x3 -> stall_out high for 66 cycles, bubbles output, then result_out=0x3_0000_0000 with regwrite_out=1.
- DIVU 100/0 -> result_out=all ones. REMU 100/7 -> result_out=2.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 64-bit ALU, branch compare/target and the EX/MEM register.
// Optional macro MULDIV_EN compiles in the iterative MUL/DIVU/REMU engine and its stall FSM.
module ex_stage #(
  parameter int XLEN      = 64,
  parameter int MD_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [3:0]      funct_in,
  input  logic [2:0]      fun3_in,
  input  logic            md_in,
  input  logic [1:0]      aluop_in,
  input  logic            memtoreg_in,
  input  logic            regwrite_in,
  input  logic            branch_in,
  input  logic            memwrite_in,
  input  logic            memread_in,
  input  logic            alusrc_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      rd_in,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] exmem_data,
  input  logic [XLEN-1:0] memwb_data,
  output logic            stall_out,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic            memtoreg_out,
  output logic            regwrite_out,
  output logic            memwrite_out,
  output logic            memread_out,
  output logic [2:0]      fun3_out,
  output logic            branch_taken_out,
  output logic [XLEN-1:0] branch_target_out
);
  localparam int SHW = $clog2(XLEN);

  if (MD_CYCLES != XLEN) begin : g_md_cfg_check
    $error("ex_stage: MD_CYCLES must equal XLEN");
  end

  logic [XLEN-1:0] op_a, fwd_b_val, op_b, alu_result;
  logic [SHW-1:0]  shamt;
  logic            is_md, lt_s, lt_u, br_cond;

  // Forwarding select 11 is reserved and falls back to the register file.
  always_comb begin
    case (fwd_a)
      2'b01:   op_a = memwb_data;
      2'b10:   op_a = exmem_data;
      default: op_a = rs1_data_in;
    endcase
    case (fwd_b)
      2'b01:   fwd_b_val = memwb_data;
      2'b10:   fwd_b_val = exmem_data;
      default: fwd_b_val = rs2_data_in;
    endcase
  end

  assign op_b  = alusrc_in ? imm_in : fwd_b_val;
  assign shamt = op_b[SHW-1:0];
  assign lt_s  = $signed(op_a) < $signed(op_b);
  assign lt_u  = op_a < op_b;
  assign is_md = (aluop_in == 2'b10) && md_in && !alusrc_in;

  always_comb begin
    alu_result = '0;
    case (aluop_in)
      2'b00: alu_result = op_a + op_b;
      2'b01: alu_result = op_a - op_b;
      2'b10: begin
        // M-extension ops never use the single-cycle ALU; the engine supplies them.
        if (!is_md) begin
          case (funct_in)
            4'b0000: alu_result = op_a + op_b;
            4'b1000: alu_result = op_a - op_b;
            4'b0111: alu_result = op_a & op_b;
            4'b0110: alu_result = op_a | op_b;
            4'b0100: alu_result = op_a ^ op_b;
            4'b0001: alu_result = op_a << shamt;
            4'b0101: alu_result = op_a >> shamt;
            4'b1101: alu_result = $signed(op_a) >>> shamt;
            4'b0010: alu_result = {{(XLEN-1){1'b0}}, lt_s};
            4'b0011: alu_result = {{(XLEN-1){1'b0}}, lt_u};
            default: alu_result = '0;
          endcase
        end
      end
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (fun3_in)
      3'b000:  br_cond = (op_a == op_b);
      3'b001:  br_cond = (op_a != op_b);
      3'b100:  br_cond = lt_s;
      3'b101:  br_cond = !lt_s;
      3'b110:  br_cond = lt_u;
      3'b111:  br_cond = !lt_u;
      default: br_cond = 1'b0;
    endcase
  end

  logic            md_bubble, md_done;
  logic [XLEN-1:0] md_result;
  logic [4:0]      md_rd;
  logic            md_memtoreg, md_regwrite, md_memwrite, md_memread;
  logic [2:0]      md_fun3;

`ifdef MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_t;
  localparam int CW = $clog2(MD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_CYCLES);

  md_state_t       md_state, md_state_next;
  logic            md_start;
  logic [XLEN-1:0] md_a, md_b, md_acc;
  logic [CW-1:0]   md_cnt;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] rem_diff;

  assign md_start = is_md && (fun3_in == 3'b000 || fun3_in == 3'b101 || fun3_in == 3'b111);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) md_state <= IDLE;
    else       md_state <= md_state_next;
  end

  always_comb begin
    md_state_next = md_state;
    stall_out     = 1'b0;
    case (md_state)
      IDLE: if (md_start) begin
        stall_out     = 1'b1;
        md_state_next = BUSY;
      end
      BUSY: begin
        stall_out = 1'b1;
        if (md_cnt == CNT_LAST) md_state_next = DONE;
      end
      DONE:    md_state_next = IDLE;
      default: md_state_next = IDLE;
    endcase
  end

  assign md_bubble = stall_out;
  assign md_done   = (md_state == DONE);

  // Restoring division: md_acc is the partial remainder, md_a shifts dividend out / quotient in.
  // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
  assign rem_sh   = {md_acc, md_a[XLEN-1]};
  assign rem_diff = {1'b0, rem_sh} - {2'b00, md_b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_a <= '0; md_b <= '0; md_acc <= '0; md_cnt <= '0; md_result <= '0;
      md_rd <= '0; md_fun3 <= '0;
      md_memtoreg <= 1'b0; md_regwrite <= 1'b0; md_memwrite <= 1'b0; md_memread <= 1'b0;
    end else if (md_state == IDLE && md_start) begin
      md_a <= op_a; md_b <= op_b; md_acc <= '0; md_cnt <= '0;
      md_rd <= rd_in; md_fun3 <= fun3_in;
      md_memtoreg <= memtoreg_in; md_regwrite <= regwrite_in;
      md_memwrite <= memwrite_in; md_memread <= memread_in;
    end else if (md_state == BUSY) begin
      if (md_cnt != CNT_LAST) begin
        md_cnt <= md_cnt + CW'(1);
        if (md_fun3 == 3'b000) begin
          if (md_b[0]) md_acc <= md_acc + md_a;
          md_a <= md_a << 1;
          md_b <= md_b >> 1;
        end else if (!rem_diff[XLEN+1]) begin
          md_acc <= rem_diff[XLEN-1:0];
          md_a   <= {md_a[XLEN-2:0], 1'b1};
        end else begin
          md_acc <= rem_sh[XLEN-1:0];
          md_a   <= {md_a[XLEN-2:0], 1'b0};
        end
      end else begin
        // Last BUSY cycle selects the final value so DONE only has to register it.
        md_result <= (md_fun3 == 3'b101) ? md_a : md_acc;
      end
    end
  end
`else
  assign stall_out   = 1'b0;
  assign md_bubble   = 1'b0;
  assign md_done     = 1'b0;
  assign md_result   = '0;
  assign md_rd       = '0;
  assign md_fun3     = '0;
  assign md_memtoreg = 1'b0;
  assign md_regwrite = 1'b0;
  assign md_memwrite = 1'b0;
  assign md_memread  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset || md_bubble) begin
      result_out <= '0; store_data_out <= '0; rd_out <= '0; fun3_out <= '0;
      memtoreg_out <= 1'b0; regwrite_out <= 1'b0; memwrite_out <= 1'b0; memread_out <= 1'b0;
      branch_taken_out <= 1'b0; branch_target_out <= '0;
    end else if (md_done) begin
      result_out <= md_result; store_data_out <= '0; rd_out <= md_rd; fun3_out <= md_fun3;
      memtoreg_out <= md_memtoreg; regwrite_out <= md_regwrite;
      memwrite_out <= md_memwrite; memread_out <= md_memread;
      branch_taken_out <= 1'b0; branch_target_out <= '0;
    end else begin
      result_out <= alu_result; store_data_out <= fwd_b_val; rd_out <= rd_in; fun3_out <= fun3_in;
      memtoreg_out <= memtoreg_in; regwrite_out <= regwrite_in;
      memwrite_out <= memwrite_in; memread_out <= memread_in;
      branch_taken_out <= branch_in & br_cond;
      branch_target_out <= pc_in + imm_in;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, random ALU ops against a
// reference model, and multi-cycle mul/div and reset-abort sequences (MULDIV_EN aware).
module tb_ex_stage;
  localparam int XLEN = 64;
`ifdef MULDIV_EN
  localparam bit MD_ON  = 1'b1;
  localparam int MD_LAT = 66;
`else
  localparam bit MD_ON  = 1'b0;
  localparam int MD_LAT = 0;
`endif

  logic clk, reset;
  logic [63:0] pc_in, rs1_data_in, rs2_data_in, imm_in, exmem_data, memwb_data;
  logic [3:0]  funct_in;
  logic [2:0]  fun3_in;
  logic        md_in, memtoreg_in, regwrite_in, branch_in, memwrite_in, memread_in, alusrc_in;
  logic [1:0]  aluop_in, fwd_a, fwd_b;
  logic [4:0]  rd_in;
  logic        stall_out, memtoreg_out, regwrite_out, memwrite_out, memread_out, branch_taken_out;
  logic [63:0] result_out, store_data_out, branch_target_out;
  logic [4:0]  rd_out;
  logic [2:0]  fun3_out;

  ex_stage #(.XLEN(64), .MD_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .funct_in(funct_in), .fun3_in(fun3_in),
    .md_in(md_in), .aluop_in(aluop_in), .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
    .branch_in(branch_in), .memwrite_in(memwrite_in), .memread_in(memread_in),
    .alusrc_in(alusrc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .imm_in(imm_in), .rd_in(rd_in), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .exmem_data(exmem_data), .memwb_data(memwb_data), .stall_out(stall_out),
    .result_out(result_out), .store_data_out(store_data_out), .rd_out(rd_out),
    .memtoreg_out(memtoreg_out), .regwrite_out(regwrite_out), .memwrite_out(memwrite_out),
    .memread_out(memread_out), .fun3_out(fun3_out), .branch_taken_out(branch_taken_out),
    .branch_target_out(branch_target_out)
  );

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  funct;
    logic [2:0]  fun3;
    logic        md;
    logic [1:0]  aluop;
    logic        memtoreg, regwrite, branch, memwrite, memread, alusrc;
    logic [63:0] rs1, rs2, imm;
    logic [4:0]  rd;
    logic [1:0]  fwd_a, fwd_b;
    logic [63:0] exmem, memwb;
  } in_t;

  typedef struct {
    in_t         i;
    logic [63:0] result;
    logic        taken;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_fwd(logic [1:0] sel, logic [63:0] rf, logic [63:0] ex, logic [63:0] wb);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return ex;
    return rf;
  endfunction

  function automatic logic [63:0] ref_b(in_t x);
    return x.alusrc ? x.imm : ref_fwd(x.fwd_b, x.rs2, x.exmem, x.memwb);
  endfunction

  function automatic logic [63:0] ref_result(in_t x);
    logic [63:0] a, b;
    int sh;
    a  = ref_fwd(x.fwd_a, x.rs1, x.exmem, x.memwb);
    b  = ref_b(x);
    sh = int'(b % 64);
    if (x.aluop == 2'd0) return a + b;
    if (x.aluop == 2'd1) return a - b;
    if (x.aluop == 2'd3) return 64'd0;
    if (x.md && !x.alusrc) begin
      if (!MD_ON) return 64'd0;
      if (x.fun3 == 3'b000) return a * b;
      if (x.fun3 == 3'b101) return (b == 0) ? ~64'd0 : a / b;
      if (x.fun3 == 3'b111) return (b == 0) ? a : a % b;
      return 64'd0;
    end
    case (x.funct)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0100: return a ^ b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return 64'($signed(a) >>> sh);
      4'b0010: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b0011: return (a < b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_taken(in_t x);
    logic [63:0] a, b;
    a = ref_fwd(x.fwd_a, x.rs1, x.exmem, x.memwb);
    b = ref_b(x);
    if (!x.branch) return 1'b0;
    case (x.fun3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic in_t mk(logic [1:0] aluop, logic [3:0] funct, logic [63:0] rs1,
                             logic [63:0] rs2, logic [63:0] imm, logic alusrc);
    in_t x;
    x = '{pc: 64'd0, funct: funct, fun3: funct[2:0], md: 1'b0, aluop: aluop,
          memtoreg: 1'b0, regwrite: 1'b1, branch: 1'b0, memwrite: 1'b0, memread: 1'b0,
          alusrc: alusrc, rs1: rs1, rs2: rs2, imm: imm, rd: 5'd7, fwd_a: 2'b00, fwd_b: 2'b00,
          exmem: 64'd0, memwb: 64'd0};
    return x;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_inputs(in_t x);
    pc_in = x.pc; funct_in = x.funct; fun3_in = x.fun3; md_in = x.md; aluop_in = x.aluop;
    memtoreg_in = x.memtoreg; regwrite_in = x.regwrite; branch_in = x.branch;
    memwrite_in = x.memwrite; memread_in = x.memread; alusrc_in = x.alusrc;
    rs1_data_in = x.rs1; rs2_data_in = x.rs2; imm_in = x.imm; rd_in = x.rd;
    fwd_a = x.fwd_a; fwd_b = x.fwd_b; exmem_data = x.exmem; memwb_data = x.memwb;
  endtask

  task automatic check_out(in_t x, logic [63:0] er, logic et, string tag);
    chk({tag, " result"}, result_out, er);
    chk({tag, " taken"}, 64'(branch_taken_out), 64'(et));
    chk({tag, " store"}, store_data_out, ref_fwd(x.fwd_b, x.rs2, x.exmem, x.memwb));
    chk({tag, " target"}, branch_target_out, x.pc + x.imm);
    chk({tag, " rd"}, 64'(rd_out), 64'(x.rd));
    chk({tag, " ctl"}, 64'({memtoreg_out, regwrite_out, memwrite_out, memread_out}),
        64'({x.memtoreg, x.regwrite, x.memwrite, x.memread}));
    chk({tag, " fun3"}, 64'(fun3_out), 64'(x.fun3));
  endtask

  task automatic run_single(in_t x, logic [63:0] er, logic et, string tag);
    @(negedge clk);
    set_inputs(x);
    #1 chk({tag, " stall"}, 64'(stall_out), 64'd0);
    @(posedge clk);
    #1 check_out(x, er, et, tag);
  endtask

  // Holds a mul/div op while stalled; expects MD_LAT stall cycles of bubbles, then the result.
  task automatic md_seq(in_t x, logic [63:0] er, string tag);
    int stall_cnt = 0;
    bit stall_bad = 0;
    bit bubble_bad = 0;
    @(negedge clk);
    set_inputs(x);
    for (int k = 0; k <= MD_LAT; k++) begin
      #1;
      if (stall_out !== (k < MD_LAT)) stall_bad = 1;
      if (stall_out === 1'b1) stall_cnt++;
      @(posedge clk);
      #1;
      if (k < MD_LAT) begin
        if ({regwrite_out, memwrite_out, memread_out, memtoreg_out, branch_taken_out} !== 5'd0 ||
            result_out !== 64'd0) bubble_bad = 1;
        @(negedge clk);
      end
    end
    chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'(MD_LAT));
    chk({tag, " stall_shape"}, 64'(stall_bad), 64'd0);
    chk({tag, " bubbles"}, 64'(bubble_bad), 64'd0);
    chk({tag, " result"}, result_out, er);
    chk({tag, " regwrite"}, 64'(regwrite_out), 64'(x.regwrite));
    chk({tag, " rd"}, 64'(rd_out), 64'(x.rd));
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[16];
  in_t  nop, x;

  initial begin
    nop = mk(2'b00, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    nop.regwrite = 1'b0;
    nop.rd = 5'd0;
    reset = 1'b1;
    set_inputs(nop);
    #1;
    chk("reset result", result_out, 64'd0);
    chk("reset ctl", 64'({memtoreg_out, regwrite_out, memwrite_out, memread_out, branch_taken_out}), 64'd0);
    chk("reset rd_fun3", 64'({rd_out, fun3_out}), 64'd0);
    chk("reset target_store", branch_target_out | store_data_out, 64'd0);
    chk("reset stall", 64'(stall_out), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed table
    tbl[0].i = mk(2'b10, 4'b1000, 64'd5, 64'd7, 64'd0, 1'b0);
    tbl[0].result = 64'hFFFF_FFFF_FFFF_FFFE; tbl[0].taken = 1'b0;
    tbl[1].i = mk(2'b00, 4'b0000, 64'h99, 64'd0, 64'd8, 1'b1);
    tbl[1].i.fwd_a = 2'b10; tbl[1].i.exmem = 64'h10;
    tbl[1].result = 64'h18; tbl[1].taken = 1'b0;
    tbl[2].i = mk(2'b01, 4'b0100, ~64'd0, 64'd1, 64'h20, 1'b0);
    tbl[2].i.branch = 1'b1; tbl[2].i.pc = 64'h100; tbl[2].i.regwrite = 1'b0;
    tbl[2].result = 64'hFFFF_FFFF_FFFF_FFFE; tbl[2].taken = 1'b1;
    tbl[3].i = mk(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 1'b0);
    tbl[3].result = 64'hF800_0000_0000_0000; tbl[3].taken = 1'b0;
    tbl[4].i = mk(2'b10, 4'b0011, 64'd1, ~64'd0, 64'd0, 1'b0);
    tbl[4].result = 64'd1; tbl[4].taken = 1'b0;
    tbl[5].i = mk(2'b10, 4'b0010, 64'd1, ~64'd0, 64'd0, 1'b0);
    tbl[5].result = 64'd0; tbl[5].taken = 1'b0;
    tbl[6].i = mk(2'b00, 4'b0011, 64'h1000, 64'h77, 64'h10, 1'b1);
    tbl[6].i.fwd_b = 2'b01; tbl[6].i.memwb = 64'h55; tbl[6].i.memwrite = 1'b1; tbl[6].i.regwrite = 1'b0;
    tbl[6].result = 64'h1010; tbl[6].taken = 1'b0;
    tbl[7].i = mk(2'b10, 4'b1001, 64'd12, 64'd3, 64'd0, 1'b0);
    tbl[7].result = 64'd0; tbl[7].taken = 1'b0;
    tbl[8].i = mk(2'b11, 4'b0000, 64'd5, 64'd6, 64'd0, 1'b0);
    tbl[8].i.memtoreg = 1'b1; tbl[8].i.memread = 1'b1;
    tbl[8].result = 64'd0; tbl[8].taken = 1'b0;
    tbl[9].i = mk(2'b01, 4'b0111, 64'd1, ~64'd0, 64'h40, 1'b0);
    tbl[9].i.branch = 1'b1; tbl[9].i.pc = 64'h2000; tbl[9].i.regwrite = 1'b0;
    tbl[9].result = 64'd2; tbl[9].taken = 1'b0;
    tbl[10].i = mk(2'b10, 4'b0001, 64'd3, 64'd65, 64'd0, 1'b0);
    tbl[10].result = 64'd6; tbl[10].taken = 1'b0;
    tbl[11].i = mk(2'b10, 4'b0001, 64'd9, 64'd9, 64'd0, 1'b0);
    tbl[11].i.md = 1'b1;
    tbl[11].result = 64'd0; tbl[11].taken = 1'b0;
    tbl[12].i = mk(2'b10, 4'b0000, 64'h20, 64'h22, 64'd0, 1'b0);
    tbl[12].i.fwd_a = 2'b11; tbl[12].i.exmem = 64'hDEAD; tbl[12].i.memwb = 64'hBEEF;
    tbl[12].result = 64'h42; tbl[12].taken = 1'b0;
    tbl[13].i = mk(2'b10, 4'b0101, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 1'b0);
    tbl[13].result = 64'd1; tbl[13].taken = 1'b0;
    tbl[14].i = mk(2'b10, 4'b0111, 64'hF0F0, 64'hFF00, 64'd0, 1'b0);
    tbl[14].result = 64'hF000; tbl[14].taken = 1'b0;
    tbl[15].i = mk(2'b10, 4'b0100, 64'hF0F0, 64'hFF00, 64'd0, 1'b0);
    tbl[15].i.fwd_b = 2'b10; tbl[15].i.exmem = 64'hFF00; tbl[15].i.rs2 = 64'd0;
    tbl[15].result = 64'h0FF0; tbl[15].taken = 1'b0;

    for (int i = 0; i < 16; i++) run_single(tbl[i].i, tbl[i].result, tbl[i].taken, $sformatf("tbl%0d", i));

    // Randomized single-cycle ops against the model
    for (int i = 0; i < 150; i++) begin
      x = mk(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      x.fun3 = (x.aluop == 2'b01) ? 3'($urandom_range(0, 7)) : x.funct[2:0];
      if (x.aluop == 2'b01 && $urandom_range(0, 1) == 1) x.rs2 = x.rs1;
      x.md = 1'($urandom_range(0, 1));
      if (MD_ON && x.md && x.aluop == 2'b10 && !x.alusrc &&
          (x.fun3 == 3'b000 || x.fun3 == 3'b101 || x.fun3 == 3'b111)) x.md = 1'b0;
      x.branch = 1'($urandom_range(0, 1)); x.memtoreg = 1'($urandom_range(0, 1));
      x.regwrite = 1'($urandom_range(0, 1)); x.memwrite = 1'($urandom_range(0, 1));
      x.memread = 1'($urandom_range(0, 1)); x.rd = 5'($urandom_range(0, 31));
      x.pc = {$urandom, $urandom}; x.fwd_a = 2'($urandom_range(0, 3)); x.fwd_b = 2'($urandom_range(0, 3));
      x.exmem = {$urandom, $urandom}; x.memwb = {$urandom, $urandom};
      run_single(x, ref_result(x), ref_taken(x), $sformatf("rnd%0d", i));
    end

    // Multiply / divide sequences
    x = mk(2'b10, 4'b0000, 64'h1_0000_0000, 64'd3, 64'd0, 1'b0);
    x.md = 1'b1; x.rd = 5'd9;
    md_seq(x, MD_ON ? 64'h3_0000_0000 : 64'd0, "mul");
    x = mk(2'b10, 4'b0101, 64'd100, 64'd0, 64'd0, 1'b0);
    x.md = 1'b1; x.rd = 5'd10;
    md_seq(x, MD_ON ? ~64'd0 : 64'd0, "divu_by0");
    x = mk(2'b10, 4'b0111, 64'd100, 64'd7, 64'd0, 1'b0);
    x.md = 1'b1; x.rd = 5'd11;
    md_seq(x, MD_ON ? 64'd2 : 64'd0, "remu");
    x = mk(2'b10, 4'b0111, 64'd100, 64'd0, 64'd0, 1'b0);
    x.md = 1'b1; x.rd = 5'd12;
    md_seq(x, MD_ON ? 64'd100 : 64'd0, "remu_by0");
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0: x = mk(2'b10, 4'b0000, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 1'b0);
        1: x = mk(2'b10, 4'b0101, {$urandom, $urandom}, 64'($urandom_range(0, 1000)), 64'd0, 1'b0);
        default: x = mk(2'b10, 4'b0111, {$urandom, $urandom}, {32'd0, $urandom}, 64'd0, 1'b0);
      endcase
      x.md = 1'b1; x.rd = 5'($urandom_range(1, 31));
      x.fwd_a = 2'($urandom_range(0, 2)); x.exmem = x.rs1 ^ 64'h5A5A; x.memwb = x.rs1 + 64'd3;
      md_seq(x, ref_result(x), $sformatf("md_rnd%0d", i));
    end

`ifdef MULDIV_EN
    // Reset in the middle of a DIVU must abort it without any late write-back
    begin
      bit late_write = 0;
      x = mk(2'b10, 4'b0101, 64'd1000, 64'd3, 64'd0, 1'b0);
      x.md = 1'b1; x.rd = 5'd13;
      @(negedge clk);
      set_inputs(x);
      repeat (10) @(posedge clk);
      #1 chk("abort busy_stall", 64'(stall_out), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      set_inputs(nop);
      #1;
      chk("abort stall", 64'(stall_out), 64'd0);
      chk("abort result", result_out, 64'd0);
      chk("abort ctl", 64'({regwrite_out, memwrite_out, memread_out, memtoreg_out, branch_taken_out}), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("abort stall_after", 64'(stall_out), 64'd0);
      for (int k = 0; k < 80; k++) begin
        @(posedge clk);
        #1;
        if (regwrite_out !== 1'b0 || result_out !== 64'd0 || stall_out !== 1'b0) late_write = 1;
      end
      chk("abort no_late_write", 64'(late_write), 64'd0);
    end
`endif
    run_single(mk(2'b00, 4'b0000, 64'd40, 64'd2, 64'd0, 1'b0), 64'd42, 1'b0, "post_add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
